// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and defaults for the pipeline controller
// Holds the 3-bit state encoding, the default DRAIN_CYCLES/CNT_BITS values
// and a helper that says which states advance the pipeline.
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_STEP_EXEC = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_HALTED    = 3'd5
  } pipe_state_t;

  localparam int unsigned DEF_DRAIN_CYCLES = 4;
  localparam int unsigned DEF_CNT_BITS     = 32;

  // States in which the pipeline registers advance.
  function automatic logic state_advances(input pipe_state_t s);
    return (s == ST_RUN) || (s == ST_STEP_EXEC) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// rtl/rise_edge_detect.sv - registered rising-edge detector
// Ports: clk, rst_n (async, active low), sig (level input),
//        pulse (high for the cycle in which sig is 1 and its last sample was 0).
module rise_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic pulse
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign pulse = sig & ~sig_q;

endmodule

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - run/step/drain/halt sequencer for the 5-stage pipeline
// Ports: clk, rst_n (async, active low); start, mode_step, step_req (host);
//        halt_detected, stall_ID_req, write_pc_req, branch_taken (ID/hazard);
//        pipe_en, write_pc, IF_ID_write, IF_ID_flush, ID_EX_bubble (register enables);
//        running, halted, step_done (status); cycle_count, bubble_count (counters).
// Optional macro PIPE_CTRL_BUBBLE_CNT_EN builds the bubble counter; otherwise
// bubble_count is tied to zero.
module pipeline_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int unsigned CNT_BITS     = DEF_CNT_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode_step,
  input  logic                step_req,
  input  logic                halt_detected,
  input  logic                stall_ID_req,
  input  logic                write_pc_req,
  input  logic                branch_taken,
  output logic                pipe_en,
  output logic                write_pc,
  output logic                IF_ID_write,
  output logic                IF_ID_flush,
  output logic                ID_EX_bubble,
  output logic                running,
  output logic                halted,
  output logic                step_done,
  output logic [CNT_BITS-1:0] cycle_count,
  output logic [CNT_BITS-1:0] bubble_count
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  pipe_state_t   state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          step_pulse;
  logic          halt_accept;

  rise_edge_detect u_step_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (step_req),
    .pulse (step_pulse)
  );

  // A stalled HALT stays in ID and is only taken on an unstalled cycle.
  assign halt_accept = halt_detected & ~stall_ID_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = mode_step ? ST_STEP_WAIT : ST_RUN;
      end
      ST_RUN: begin
        if (halt_accept) begin
          state_d = ST_DRAIN;
          drain_d = DW'(DRAIN_CYCLES - 1);
        end
      end
      ST_STEP_WAIT: begin
        if (step_pulse) state_d = ST_STEP_EXEC;
      end
      ST_STEP_EXEC: begin
        if (halt_accept) begin
          state_d = ST_DRAIN;
          drain_d = DW'(DRAIN_CYCLES - 1);
        end else begin
          state_d = ST_STEP_WAIT;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) state_d = ST_HALTED;
        else               drain_d = drain_q - DW'(1);
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Enables are combinational on the hazard inputs and forced low when the
  // pipeline is not advancing.
  always_comb begin
    pipe_en      = state_advances(state_q);
    write_pc     = 1'b0;
    IF_ID_write  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    if (pipe_en) begin
      write_pc     = write_pc_req & (state_q != ST_DRAIN);
      IF_ID_write  = ~stall_ID_req;
      ID_EX_bubble = stall_ID_req;
      IF_ID_flush  = (branch_taken & ~stall_ID_req) | (state_q == ST_DRAIN);
    end
  end

  assign running   = pipe_en || (state_q == ST_STEP_WAIT);
  assign halted    = (state_q == ST_HALTED);
  assign step_done = (state_q == ST_STEP_EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
    end else if (pipe_en && (cycle_count != '1)) begin
      cycle_count <= cycle_count + CNT_BITS'(1);
    end
  end

`ifdef PIPE_CTRL_BUBBLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count <= '0;
    end else if (ID_EX_bubble && (bubble_count != '1)) begin
      bubble_count <= bubble_count + CNT_BITS'(1);
    end
  end
`else
  assign bubble_count = '0;
`endif

endmodule
